// File: rtl/srl_fifo_pkg.sv
// ---------------------------------------------------------------------------
// srl_fifo_pkg : shared types and sizes for the SRL16-style FIFO. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package srl_fifo_pkg;

  localparam int DEPTH_MAX = 16;
  localparam int CNT_W     = 5;
  localparam int ADDR_W    = 4;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/srl_fifo_storage.sv
// ---------------------------------------------------------------------------
// srl_fifo_storage : WIDTH addressable 16-bit shift columns, shared CE/address.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module srl_fifo_storage
  import srl_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              CLK,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  // Columns are deliberately unreset so they map onto shift-register LUTs.
  for (genvar i = 0; i < WIDTH; i++) begin : g_col
    logic [DEPTH_MAX-1:0] col_q;
    logic [DEPTH_MAX-1:0] col_d;

    always_comb begin
      col_d = col_q;
      if (ce) begin
        col_d = {col_q[DEPTH_MAX-2:0], din[i]};
      end
    end

    always_ff @(posedge CLK) begin
      col_q <= col_d;
    end

    assign dout[i] = col_q[addr];
  end

endmodule

`default_nettype wire

// File: rtl/srl_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// srl_fifo_ctrl : valid/ready FIFO controller over SRL storage; optional
// almost_full/almost_empty flags under SRL_FIFO_ALMOST_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
`ifdef SRL_FIFO_ALMOST_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if (WIDTH < 1 || WIDTH > 64 || DEPTH < 2 || DEPTH > DEPTH_MAX ||
      AFULL_THRESH < 0 || AFULL_THRESH > DEPTH ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_param_check
    $error("srl_fifo_ctrl: parameter out of range");
  end

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;

  // Handshakes depend on state only, so no input-to-ready/valid path exists.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign rd_addr = (count_q == '0) ? '0 : ADDR_W'(count_q - 1'b1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          count_d = count_q + 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (push && !pop) begin
          count_d = count_q + 1'b1;
          if (count_d == DEPTH_C) state_d = FULL;
        end else if (pop && !push) begin
          count_d = count_q - 1'b1;
          if (count_d == '0) state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          count_d = count_q - 1'b1;
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = EMPTY;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  srl_fifo_storage #(
    .WIDTH (WIDTH)
  ) u_storage (
    .CLK  (CLK),
    .ce   (push),
    .addr (rd_addr),
    .din  (in_data),
    .dout (rd_data)
  );

  // Storage is never cleared, so the mask is what hides stale entries.
  assign out_data = out_valid ? rd_data : '0;
  assign count    = count_q;

`ifdef SRL_FIFO_ALMOST_EN
  logic almost_full_q;
  logic almost_full_d;
  logic almost_empty_q;
  logic almost_empty_d;

  always_comb begin
    almost_full_d  = (count_d >= CNT_W'(AFULL_THRESH));
    almost_empty_d = (count_d <= CNT_W'(AEMPTY_THRESH));
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_srl_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_srl_fifo_ctrl : vector table, corner sequences and random traffic
// against a queue model of the FIFO. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_srl_fifo_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic             CLK = 1'b0;
  logic             CLR = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       count;
`ifdef SRL_FIFO_ALMOST_EN
  logic             almost_full;
  logic             almost_empty;
`endif

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] model_q[$];

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             r;
    int               ecount;
    logic             eov;
    logic [WIDTH-1:0] edata;
    logic             eir;
  } vec_t;

  vec_t tbl[8];

  always #5 CLK = ~CLK;

  srl_fifo_ctrl #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count)
`ifdef SRL_FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"},     32'(count),     32'(n));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    chk({tag, ".out_data"},  32'(out_data),  32'((n != 0) ? model_q[0] : 8'h00));
`ifdef SRL_FIFO_ALMOST_EN
    chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
`endif
  endtask

  // Called at a falling edge: drive, take one rising edge, check at next fall.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input string tag);
    bit do_push;
    bit do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() > 0);
    @(posedge CLK);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    @(negedge CLK);
    check_model(tag);
  endtask

  initial begin
    // A=5A B=A1 C=B2 D=C3: fall-through, push+pop at count 3, then drain.
    tbl[0] = '{1'b1, 8'h5A, 1'b0, 1, 1'b1, 8'h5A, 1'b1};
    tbl[1] = '{1'b1, 8'hA1, 1'b0, 2, 1'b1, 8'h5A, 1'b1};
    tbl[2] = '{1'b1, 8'hB2, 1'b0, 3, 1'b1, 8'h5A, 1'b1};
    tbl[3] = '{1'b1, 8'hC3, 1'b1, 3, 1'b1, 8'hA1, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'hB2, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'hC3, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};
    tbl[7] = '{1'b0, 8'hFF, 1'b1, 0, 1'b0, 8'h00, 1'b1};

    CLR = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset.count",     32'(count),     32'd0);
    chk("reset.in_ready",  32'(in_ready),  32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_data",  32'(out_data),  32'd0);
`ifdef SRL_FIFO_ALMOST_EN
    chk("reset.almost_full",  32'(almost_full),  32'd0);
    chk("reset.almost_empty", 32'(almost_empty), 32'd1);
`endif
    CLR = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r, "tbl");
      chk($sformatf("tbl%0d.count", i),     32'(count),     32'(tbl[i].ecount));
      chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      chk($sformatf("tbl%0d.out_data", i),  32'(out_data),  32'(tbl[i].edata));
      chk($sformatf("tbl%0d.in_ready", i),  32'(in_ready),  32'(tbl[i].eir));
    end

    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, "fill");
`ifdef SRL_FIFO_ALMOST_EN
      if (i == 2)  chk("fill.ae_at2",  32'(almost_empty), 32'd1);
      if (i == 3)  chk("fill.ae_at3",  32'(almost_empty), 32'd0);
      if (i == 13) chk("fill.af_at13", 32'(almost_full),  32'd0);
      if (i == 14) chk("fill.af_at14", 32'(almost_full),  32'd1);
`endif
    end
    chk("fill.count16",  32'(count),    32'd16);
    chk("fill.in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 8'hEE, 1'b0, "overfill");
    chk("overfill.count", 32'(count), 32'd16);

    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("drain.head%0d", i), 32'(out_data), 32'(i));
      step(i == 1, 8'hEE, 1'b1, "drain");
    end
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, "pre_clr");
    chk("pre_clr.count", 32'(count), 32'd7);
    #2 CLR = 1'b0;
    #1;
    chk("clr_async.count",     32'(count),     32'd0);
    chk("clr_async.out_valid", 32'(out_valid), 32'd0);
    chk("clr_async.out_data",  32'(out_data),  32'd0);
    chk("clr_async.in_ready",  32'(in_ready),  32'd1);
    in_valid = 1'b1;
    in_data  = 8'h77;
    model_q.delete();
    @(negedge CLK);
    check_model("clr_hold");
    CLR = 1'b1;
    step(1'b1, 8'h33, 1'b0, "post_clr");
    chk("post_clr.out_data", 32'(out_data), 32'h33);

    for (int i = 0; i < 3000; i++) begin
      int pth;
      case ((i / 250) % 4)
        0:       pth = 3;
        1:       pth = 1;
        default: pth = 2;
      endcase
      step($urandom_range(0, 3) < pth, 8'($urandom), $urandom_range(0, 3) >= pth, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
